// File: rtl/xbar_arb_2x2_pkg.sv
// Shared constants and types for the 2x2 crossbar arbiter.
// Encodings for the crossbar select, the destination tags and the priority pointer.
package xbar_arb_2x2_pkg;

  localparam int DW_DEFAULT = 4;

  localparam logic CTRL_STRAIGHT = 1'b0;
  localparam logic CTRL_SWAP     = 1'b1;

  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;

  typedef enum logic {
    PRIO_IN1 = 1'b0,
    PRIO_IN2 = 1'b1
  } prio_e;

endpackage

// File: rtl/xbar_arb_2x2_if.sv
// Handshake bundle between the two producer lanes, the arbiter and the two consumer lanes.
// The master modport is the surrounding environment; the slave modport is the arbiter.
interface xbar_arb_2x2_if
  import xbar_arb_2x2_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = 8
);

  logic          in1_valid;
  logic          in1_dest;
  logic [DW-1:0] in1_data;
  logic          in1_ready;
  logic          in2_valid;
  logic          in2_dest;
  logic [DW-1:0] in2_data;
  logic          in2_ready;

  logic          out1_valid;
  logic [DW-1:0] out1_data;
  logic          out1_ready;
  logic          out2_valid;
  logic [DW-1:0] out2_data;
  logic          out2_ready;

  logic             control;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output in1_valid, in1_dest, in1_data, in2_valid, in2_dest, in2_data,
    output out1_ready, out2_ready,
    input  in1_ready, in2_ready,
    input  out1_valid, out1_data, out2_valid, out2_data,
    input  control, conflict_cnt
  );

  modport slave (
    input  in1_valid, in1_dest, in1_data, in2_valid, in2_dest, in2_data,
    input  out1_ready, out2_ready,
    output in1_ready, in2_ready,
    output out1_valid, out1_data, out2_valid, out2_data,
    output control, conflict_cnt
  );

endinterface

// File: rtl/Crossbar_2x2_4bit.sv
// Existing 2x2 4-bit crossbar: control=0 passes straight, control=1 swaps the lanes.
module Crossbar_2x2_4bit (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       control,
  output logic [3:0] out1,
  output logic [3:0] out2
);

  assign out1 = control ? in2 : in1;
  assign out2 = control ? in1 : in2;

endmodule

// File: rtl/xbar_arb_2x2_rr_ptr_2.sv
// Two-way round-robin pointer: names the requester that wins a same-port contention.
// After a contention that produced a grant, priority passes to the other requester.
module rr_ptr_2
  import xbar_arb_2x2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic advance_i,
  output logic win_in2_o
);

  prio_e ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (ptr_q == PRIO_IN1) ? PRIO_IN2 : PRIO_IN1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PRIO_IN1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign win_in2_o = (ptr_q == PRIO_IN2);

endmodule

// File: rtl/xbar_arb_2x2.sv
// Round-robin arbiter and scheduler for the 2x2 crossbar, with a one-entry
// output register per port and valid/ready handshakes on both sides.
module xbar_arb_2x2
  import xbar_arb_2x2_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  xbar_arb_2x2_if.slave bus
);

  logic avail1, avail2;
  logic tgt_avail1, tgt_avail2;
  logic same_dest;
  logic win_in2;
  logic grant1, grant2;
  logic contend_won;
  logic load1, load2;
  logic ctrl_d, ctrl_q;

  logic [3:0] xbar_out1, xbar_out2;

  logic             out1_valid_q, out1_valid_d;
  logic             out2_valid_q, out2_valid_d;
  logic [DW-1:0]    out1_data_q, out1_data_d;
  logic [DW-1:0]    out2_data_q, out2_data_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // A full register being drained this cycle can take a new word in the same cycle.
  always_comb begin
    avail1      = !out1_valid_q | bus.out1_ready;
    avail2      = !out2_valid_q | bus.out2_ready;
    tgt_avail1  = (bus.in1_dest == DEST_OUT2) ? avail2 : avail1;
    tgt_avail2  = (bus.in2_dest == DEST_OUT2) ? avail2 : avail1;
    same_dest   = bus.in1_valid & bus.in2_valid & (bus.in1_dest == bus.in2_dest);
    grant1      = !rst & bus.in1_valid & tgt_avail1 & (!same_dest | !win_in2);
    grant2      = !rst & bus.in2_valid & tgt_avail2 & (!same_dest |  win_in2);
    contend_won = same_dest & (grant1 | grant2);
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (grant1) begin
      ctrl_d = (bus.in1_dest == DEST_OUT2) ? CTRL_SWAP : CTRL_STRAIGHT;
    end else if (grant2) begin
      ctrl_d = (bus.in2_dest == DEST_OUT1) ? CTRL_SWAP : CTRL_STRAIGHT;
    end
  end

  rr_ptr_2 u_rr_ptr (
    .clk       (clk),
    .rst       (rst),
    .advance_i (contend_won),
    .win_in2_o (win_in2)
  );

  Crossbar_2x2_4bit u_crossbar (
    .in1     (bus.in1_data),
    .in2     (bus.in2_data),
    .control (ctrl_d),
    .out1    (xbar_out1),
    .out2    (xbar_out2)
  );

  always_comb begin
    load1 = (grant1 & (bus.in1_dest == DEST_OUT1)) | (grant2 & (bus.in2_dest == DEST_OUT1));
    load2 = (grant1 & (bus.in1_dest == DEST_OUT2)) | (grant2 & (bus.in2_dest == DEST_OUT2));

    out1_valid_d   = out1_valid_q & !bus.out1_ready;
    out1_data_d    = out1_data_q;
    out2_valid_d   = out2_valid_q & !bus.out2_ready;
    out2_data_d    = out2_data_q;
    conflict_cnt_d = conflict_cnt_q;

    if (load1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = xbar_out1;
    end
    if (load2) begin
      out2_valid_d = 1'b1;
      out2_data_d  = xbar_out2;
    end
    // Saturate instead of wrapping so a long-running count never reads as low.
    if (contend_won && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_valid_q   <= 1'b0;
      out2_valid_q   <= 1'b0;
      out1_data_q    <= '0;
      out2_data_q    <= '0;
      conflict_cnt_q <= '0;
      ctrl_q         <= CTRL_STRAIGHT;
    end else begin
      out1_valid_q   <= out1_valid_d;
      out2_valid_q   <= out2_valid_d;
      out1_data_q    <= out1_data_d;
      out2_data_q    <= out2_data_d;
      conflict_cnt_q <= conflict_cnt_d;
      ctrl_q         <= ctrl_d;
    end
  end

  assign bus.in1_ready    = grant1;
  assign bus.in2_ready    = grant2;
  assign bus.out1_valid   = out1_valid_q;
  assign bus.out1_data    = out1_data_q;
  assign bus.out2_valid   = out2_valid_q;
  assign bus.out2_data    = out2_data_q;
  assign bus.control      = ctrl_d;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_xbar_arb_2x2.sv
// Self-checking bench for xbar_arb_2x2: two instances (8-bit and 2-bit counter) share
// one stimulus stream and are checked every cycle against a port-centric reference model.
module tb_xbar_arb_2x2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  xbar_arb_2x2_if #(.DW(4), .CNT_W(8)) ifA ();
  xbar_arb_2x2_if #(.DW(4), .CNT_W(2)) ifB ();

  // The narrow-counter instance mirrors every input of the main one.
  assign ifB.in1_valid  = ifA.in1_valid;
  assign ifB.in1_dest   = ifA.in1_dest;
  assign ifB.in1_data   = ifA.in1_data;
  assign ifB.in2_valid  = ifA.in2_valid;
  assign ifB.in2_dest   = ifA.in2_dest;
  assign ifB.in2_data   = ifA.in2_data;
  assign ifB.out1_ready = ifA.out1_ready;
  assign ifB.out2_ready = ifA.out2_ready;

  xbar_arb_2x2 #(.DW(4), .CNT_W(8)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  xbar_arb_2x2 #(.DW(4), .CNT_W(2)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  int tests  = 0;
  int failed = 0;

  // Reference model state, seen per output port rather than per register.
  bit       modelReady = 1'b0;
  bit       mValid[2];
  bit [3:0] mData[2];
  int       prio = 0;
  bit       mCtrl = 1'b0;
  int       cntA = 0;
  int       cntB = 0;

  // Per-cycle results of the model's arbitration.
  bit       reqV[2];
  bit       reqD[2];
  bit [3:0] reqX[2];
  bit       outRdy[2];
  bit       eg[2];
  bit       expCtrl;
  bit       contended;
  int       winner;

  task automatic checkEq(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v1, input bit d1, input bit [3:0] x1,
                               input bit v2, input bit d2, input bit [3:0] x2,
                               input bit r1, input bit r2, input bit rs);
    ifA.in1_valid  = v1;
    ifA.in1_dest   = d1;
    ifA.in1_data   = x1;
    ifA.in2_valid  = v2;
    ifA.in2_dest   = d2;
    ifA.in2_data   = x2;
    ifA.out1_ready = r1;
    ifA.out2_ready = r2;
    rst            = rs;
  endtask

  // For each output port, look at who wants it and decide who gets it.
  task automatic modelEval();
    int n;
    int who[2];
    reqV[0] = ifA.in1_valid;  reqD[0] = ifA.in1_dest;  reqX[0] = ifA.in1_data;
    reqV[1] = ifA.in2_valid;  reqD[1] = ifA.in2_dest;  reqX[1] = ifA.in2_data;
    outRdy[0] = ifA.out1_ready;
    outRdy[1] = ifA.out2_ready;
    eg[0] = 1'b0;
    eg[1] = 1'b0;
    contended = 1'b0;
    winner = -1;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        n = 0;
        for (int i = 0; i < 2; i++) begin
          if (reqV[i] && (int'(reqD[i]) == k)) begin
            who[n] = i;
            n++;
          end
        end
        if (!mValid[k] || outRdy[k]) begin
          if (n == 1) begin
            eg[who[0]] = 1'b1;
          end else if (n == 2) begin
            eg[prio] = 1'b1;
            contended = 1'b1;
            winner = prio;
          end
        end
      end
    end
    expCtrl = mCtrl;
    for (int i = 0; i < 2; i++) begin
      if (eg[i]) expCtrl = (int'(reqD[i]) != i);
    end
  endtask

  task automatic modelCommit();
    bit loaded;
    if (rst) begin
      mValid[0] = 1'b0;  mValid[1] = 1'b0;
      mData[0]  = 4'h0;  mData[1]  = 4'h0;
      prio = 0;
      mCtrl = 1'b0;
      cntA = 0;
      cntB = 0;
      modelReady = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        loaded = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (eg[i] && (int'(reqD[i]) == k)) begin
            mData[k]  = reqX[i];
            mValid[k] = 1'b1;
            loaded    = 1'b1;
          end
        end
        if (!loaded && outRdy[k]) mValid[k] = 1'b0;
      end
      if (contended) begin
        prio = 1 - winner;
        if (cntA < 255) cntA++;
        if (cntB < 3) cntB++;
      end
      mCtrl = expCtrl;
    end
  endtask

  task automatic checkOutput();
    if (!modelReady) return;
    checkEq("in1_ready",    8'(ifA.in1_ready),    8'(eg[0]));
    checkEq("in2_ready",    8'(ifA.in2_ready),    8'(eg[1]));
    checkEq("control",      8'(ifA.control),      8'(expCtrl));
    checkEq("out1_valid",   8'(ifA.out1_valid),   8'(mValid[0]));
    checkEq("out2_valid",   8'(ifA.out2_valid),   8'(mValid[1]));
    checkEq("out1_data",    8'(ifA.out1_data),    8'(mData[0]));
    checkEq("out2_data",    8'(ifA.out2_data),    8'(mData[1]));
    checkEq("conflict_cnt", ifA.conflict_cnt,     8'(cntA));
    checkEq("sat_cnt",      8'(ifB.conflict_cnt), 8'(cntB));
    checkEq("sat_control",  8'(ifB.control),      8'(expCtrl));
  endtask

  // Inputs are stable from just after the rising edge; outputs are judged on the falling edge.
  task automatic settle();
    @(negedge clk);
    modelEval();
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  bit       hold[2];
  bit       rv[2];
  bit       rd[2];
  bit [3:0] rx[2];
  bit       rr[2];
  bit       rrs;

  initial begin
    applyStimulus(0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 1);

    // Two reset cycles, then an idle cycle.
    settle(); tick();
    settle();
    checkEq("lit_rst_out1_valid", 8'(ifA.out1_valid), 8'h00);
    checkEq("lit_rst_out2_valid", 8'(ifA.out2_valid), 8'h00);
    checkEq("lit_rst_cnt",        ifA.conflict_cnt,   8'h00);
    checkEq("lit_rst_ready",      8'(ifA.in1_ready),  8'h00);
    tick();
    applyStimulus(0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 0);
    settle();
    checkEq("lit_idle_control", 8'(ifA.control), 8'h00);
    tick();

    // Straight pass.
    applyStimulus(1, 0, 4'hA, 1, 1, 4'h5, 1, 1, 0);
    settle();
    checkEq("lit_straight_r1",   8'(ifA.in1_ready), 8'h01);
    checkEq("lit_straight_r2",   8'(ifA.in2_ready), 8'h01);
    checkEq("lit_straight_ctrl", 8'(ifA.control),   8'h00);
    tick();

    // Swap.
    applyStimulus(1, 1, 4'h3, 1, 0, 4'hC, 1, 1, 0);
    settle();
    checkEq("lit_straight_out1", 8'(ifA.out1_data), 8'h0A);
    checkEq("lit_straight_out2", 8'(ifA.out2_data), 8'h05);
    checkEq("lit_swap_ctrl",     8'(ifA.control),   8'h01);
    tick();
    applyStimulus(0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 0);
    settle();
    checkEq("lit_swap_out1", 8'(ifA.out1_data), 8'h0C);
    checkEq("lit_swap_out2", 8'(ifA.out2_data), 8'h03);
    tick();
    settle();
    checkEq("lit_swap_hold_ctrl", 8'(ifA.control), 8'h01);
    tick();

    // Contention on out1, held for two cycles.
    applyStimulus(1, 0, 4'h1, 1, 0, 4'h2, 1, 1, 0);
    settle();
    checkEq("lit_rr0_r1", 8'(ifA.in1_ready), 8'h01);
    checkEq("lit_rr0_r2", 8'(ifA.in2_ready), 8'h00);
    tick();
    settle();
    checkEq("lit_rr1_r1",   8'(ifA.in1_ready), 8'h00);
    checkEq("lit_rr1_r2",   8'(ifA.in2_ready), 8'h01);
    checkEq("lit_rr1_ctrl", 8'(ifA.control),   8'h01);
    checkEq("lit_rr1_out1", 8'(ifA.out1_data), 8'h01);
    tick();
    applyStimulus(0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 0);
    settle();
    checkEq("lit_rr_out1", 8'(ifA.out1_data),  8'h02);
    checkEq("lit_rr_cnt",  ifA.conflict_cnt,   8'h02);
    tick();

    // Backpressure on out2.
    applyStimulus(1, 1, 4'h7, 0, 0, 4'h0, 1, 0, 0);
    settle(); tick();
    applyStimulus(1, 1, 4'h9, 0, 0, 4'h0, 1, 0, 0);
    settle();
    checkEq("lit_bp_blocked", 8'(ifA.in1_ready), 8'h00);
    tick();
    applyStimulus(1, 1, 4'h9, 0, 0, 4'h0, 1, 1, 0);
    settle();
    checkEq("lit_bp_drain", 8'(ifA.in1_ready), 8'h01);
    tick();
    applyStimulus(0, 0, 4'h0, 0, 0, 4'h0, 1, 0, 0);
    settle();
    checkEq("lit_bp_out2", 8'(ifA.out2_data), 8'h09);
    tick();
    applyStimulus(1, 0, 4'h1, 1, 0, 4'h2, 1, 0, 0);
    settle();
    checkEq("lit_ptr_kept", 8'(ifA.in1_ready), 8'h01);
    tick();

    // Two more contentions: five in total saturates the 2-bit counter.
    settle(); tick();
    settle(); tick();
    applyStimulus(0, 0, 4'h0, 0, 0, 4'h0, 1, 1, 0);
    settle();
    checkEq("lit_sat_cnt2", 8'(ifB.conflict_cnt), 8'h03);
    checkEq("lit_sat_cnt8", ifA.conflict_cnt,     8'h05);
    tick();

    // Reset while out1 holds a word.
    applyStimulus(1, 0, 4'hE, 0, 0, 4'h0, 0, 1, 0);
    settle(); tick();
    applyStimulus(1, 0, 4'hE, 0, 0, 4'h0, 0, 1, 1);
    settle();
    checkEq("lit_mid_rst_ready", 8'(ifA.in1_ready),  8'h00);
    checkEq("lit_mid_rst_full",  8'(ifA.out1_valid), 8'h01);
    tick();
    applyStimulus(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0);
    settle();
    checkEq("lit_post_rst_valid", 8'(ifA.out1_valid), 8'h00);
    tick();

    // Randomised traffic; a refused requester keeps its word until accepted or reset.
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rrs = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          rv[i] = ($urandom_range(0, 3) != 0);
          rd[i] = 1'($urandom_range(0, 1));
          rx[i] = 4'($urandom_range(0, 15));
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(rv[0], rd[0], rx[0], rv[1], rd[1], rx[1], rr[0], rr[1], rrs);
      settle();
      for (int i = 0; i < 2; i++) hold[i] = rv[i] && !eg[i] && !rrs;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
